// File: rtl/do_hall_pkg.sv
// Shared Hall-sequence definitions for the multi-channel DO Hall generator.
// Table literals are written {A,B,C}; the HALL_BIT_* constants place them on the bus.
package do_hall_pkg;

  localparam int HALL_BIT_A = 2;
  localparam int HALL_BIT_B = 1;
  localparam int HALL_BIT_C = 0;

  localparam logic [2:0] IDX_MAX = 3'd5;

  typedef enum logic [2:0] {
    IDX_0 = 3'd0,
    IDX_1 = 3'd1,
    IDX_2 = 3'd2,
    IDX_3 = 3'd3,
    IDX_4 = 3'd4,
    IDX_5 = 3'd5
  } hall_idx_e;

  localparam logic [2:0] HALL_SEQ_120 [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  localparam logic [2:0] HALL_SEQ_60  [6] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};

  function automatic logic [2:0] hall_lookup(input hall_idx_e idx, input logic phase120);
    logic [2:0] code;
    logic [2:0] out;
    code = 3'b000;
    if (idx <= IDX_MAX) begin
      code = phase120 ? HALL_SEQ_120[idx] : HALL_SEQ_60[idx];
    end
    out = 3'b000;
    out[HALL_BIT_A] = code[2];
    out[HALL_BIT_B] = code[1];
    out[HALL_BIT_C] = code[0];
    return out;
  endfunction

  // Modulo-6 walk; anything outside 0..5 lands on IDX_0.
  function automatic hall_idx_e idx_advance(input hall_idx_e idx, input logic fwd);
    hall_idx_e nxt;
    case (idx)
      IDX_0:   nxt = fwd ? IDX_1 : IDX_5;
      IDX_1:   nxt = fwd ? IDX_2 : IDX_0;
      IDX_2:   nxt = fwd ? IDX_3 : IDX_1;
      IDX_3:   nxt = fwd ? IDX_4 : IDX_2;
      IDX_4:   nxt = fwd ? IDX_5 : IDX_3;
      IDX_5:   nxt = fwd ? IDX_0 : IDX_4;
      default: nxt = IDX_0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/do_hall_chan.sv
// One Hall channel: prescaled step timer, six-state index, shadowed period reload,
// wrapping position counter and registered {A,B,C} output.
module do_hall_chan
  import do_hall_pkg::*;
#(
  parameter int PW   = 32,
  parameter int POSW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PW-1:0]   period_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic            dir_i,
  input  logic            phase_i,
  output logic [2:0]      hall_o,
  output logic            step_o,
  output logic [POSW-1:0] pos_o
);

  logic [PW-1:0]   shadow_q, shadow_d;
  logic [PW-1:0]   active_q, active_d;
  logic [PW-1:0]   presc_q,  presc_d;
  hall_idx_e       idx_q,    idx_d;
  logic            started_q, started_d;
  logic [2:0]      hall_q,   hall_d;
  logic            step_q,   step_d;
  logic [POSW-1:0] pos_q,    pos_d;
  logic            step_evt;

  // A load on the step edge bypasses the shadow so it governs the very next interval.
  always_comb begin
    step_evt  = en_i && (presc_q == active_q);
    shadow_d  = load_i ? period_i : shadow_q;
    active_d  = active_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    pos_d     = pos_q;

    if (step_evt || !en_i) begin
      active_d = shadow_d;
    end

    if (!en_i || step_evt) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (idx_q > IDX_MAX) begin
      idx_d = IDX_0;
    end else if (step_evt) begin
      idx_d = idx_advance(idx_q, dir_i);
    end

    if (step_evt) begin
      pos_d = dir_i ? (pos_q + POSW'(1)) : (pos_q - POSW'(1));
    end

    started_d = started_q | step_evt;
    hall_d    = started_d ? hall_lookup(idx_d, phase_i) : 3'b000;
    step_d    = step_evt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      presc_q   <= '0;
      idx_q     <= IDX_0;
      started_q <= 1'b0;
      hall_q    <= 3'b000;
      step_q    <= 1'b0;
      pos_q     <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      hall_q    <= hall_d;
      step_q    <= step_d;
      pos_q     <= pos_d;
    end
  end

  assign hall_o = hall_q;
  assign step_o = step_q;
  assign pos_o  = pos_q;

endmodule

// File: rtl/do_hall_multi.sv
// NUM_CH independent Hall output channels between the DSP registers and the DO pin mux.
// Channel k occupies slice k of every bus.
module do_hall_multi #(
  parameter int NUM_CH = 3,
  parameter int PW     = 32,
  parameter int POSW   = 16
) (
  input  logic                   xclk,
  input  logic                   reset,
  input  logic [NUM_CH*PW-1:0]   period_in,
  input  logic [NUM_CH-1:0]      period_load,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic [NUM_CH-1:0]      hall_dir,
  input  logic [NUM_CH-1:0]      hall_phase,
  output logic [NUM_CH*3-1:0]    hall_out,
  output logic [NUM_CH-1:0]      step_pulse,
  output logic [NUM_CH*POSW-1:0] pos_count
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    do_hall_chan #(
      .PW   (PW),
      .POSW (POSW)
    ) u_chan (
      .clk_i    (xclk),
      .rst_i    (reset),
      .period_i (period_in[k*PW +: PW]),
      .load_i   (period_load[k]),
      .en_i     (ch_en[k]),
      .dir_i    (hall_dir[k]),
      .phase_i  (hall_phase[k]),
      .hall_o   (hall_out[k*3 +: 3]),
      .step_o   (step_pulse[k]),
      .pos_o    (pos_count[k*POSW +: POSW])
    );
  end

endmodule

// File: tb/tb_do_hall_multi.sv
// Self-checking bench for do_hall_multi: directed scenarios plus randomized traffic,
// compared against a timestamp-based model of step scheduling.
module tb_do_hall_multi;

  localparam int NCH  = 3;
  localparam int PW   = 32;
  localparam int POSW = 16;

  logic                  xclk = 1'b0;
  logic                  reset = 1'b1;
  logic [NCH*PW-1:0]     periodIn = '0;
  logic [NCH-1:0]        periodLoad = '0;
  logic [NCH-1:0]        chEn = '0;
  logic [NCH-1:0]        hallDir = '0;
  logic [NCH-1:0]        hallPhase = '0;
  logic [NCH*3-1:0]      hallOut;
  logic [NCH-1:0]        stepPulse;
  logic [NCH*POSW-1:0]   posCount;

  logic [7:0] wPeriod = '0;
  logic [0:0] wLoad = '0, wEn = '0, wDir = '0, wPhase = '0;
  logic [2:0] wHall;
  logic [0:0] wStep;
  logic [3:0] wPos;

  int nChecks = 0;
  int nFails  = 0;

  // Model: each channel keeps the absolute cycle number of its next step.
  longint     cycleNo = 0;
  longint     mDue[NCH];
  int         mShadow[NCH];
  int         mIdx[NCH];
  int         mPos[NCH];
  bit         mStarted[NCH];
  bit         mStep[NCH];
  logic [2:0] mHall[NCH];

  logic [2:0] seq120 [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [2:0] seq60  [6] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};

  always #7 xclk = ~xclk;

  do_hall_multi #(.NUM_CH(NCH), .PW(PW), .POSW(POSW)) dut (
    .xclk        (xclk),
    .reset       (reset),
    .period_in   (periodIn),
    .period_load (periodLoad),
    .ch_en       (chEn),
    .hall_dir    (hallDir),
    .hall_phase  (hallPhase),
    .hall_out    (hallOut),
    .step_pulse  (stepPulse),
    .pos_count   (posCount)
  );

  do_hall_multi #(.NUM_CH(1), .PW(8), .POSW(4)) wrapDut (
    .xclk        (xclk),
    .reset       (reset),
    .period_in   (wPeriod),
    .period_load (wLoad),
    .ch_en       (wEn),
    .hall_dir    (wDir),
    .hall_phase  (wPhase),
    .hall_out    (wHall),
    .step_pulse  (wStep),
    .pos_count   (wPos)
  );

  task automatic tick();
    int shadowNew;
    @(posedge xclk);
    cycleNo++;
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        mShadow[c] = 0; mIdx[c] = 0; mPos[c] = 0;
        mStarted[c] = 0; mStep[c] = 0; mHall[c] = 3'b000;
        mDue[c] = cycleNo + 1;
      end else begin
        shadowNew = periodLoad[c] ? int'(periodIn[c*PW +: PW]) : mShadow[c];
        mStep[c] = chEn[c] && (cycleNo == mDue[c]);
        if (mStep[c]) begin
          mIdx[c] = hallDir[c] ? (mIdx[c] + 1) % 6 : (mIdx[c] + 5) % 6;
          mPos[c] = hallDir[c] ? (mPos[c] + 1) % 65536 : (mPos[c] + 65535) % 65536;
          mStarted[c] = 1;
          mDue[c] = cycleNo + shadowNew + 1;
        end else if (!chEn[c]) begin
          mDue[c] = cycleNo + shadowNew + 1;
        end
        mShadow[c] = shadowNew;
        mHall[c] = !mStarted[c] ? 3'b000 : (hallPhase[c] ? seq120[mIdx[c]] : seq60[mIdx[c]]);
      end
    end
    @(negedge xclk);
  endtask

  // Ticks until channel ch pulses; n is the clocks taken, or -1 if the bound expired.
  task automatic waitStep(input int ch, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!stepPulse[ch] && n < bound);
    if (!stepPulse[ch]) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    chEn = '0;
    repeat (4) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        nChecks++;
        if (hallOut[c*3 +: 3] !== 3'b000 || stepPulse[c] !== 1'b0 || posCount[c*POSW +: POSW] !== 16'h0000) begin
          nFails++;
          $display("[TB] FAIL reset_idle ch%0d: got hall=%b step=%b pos=%h, want 000/0/0000",
                   c, hallOut[c*3 +: 3], stepPulse[c], posCount[c*POSW +: POSW]);
        end
      end
      nChecks++;
      if (wHall !== 3'b000 || wStep !== 1'b0 || wPos !== 4'h0) begin
        nFails++;
        $display("[TB] FAIL reset_idle wrapDut: got hall=%b step=%b pos=%h, want 000/0/0", wHall, wStep, wPos);
      end
    end
  endtask

  task automatic test_fwd120();
    int steps = 0;
    periodIn[0 +: PW] = 32'd2;
    periodLoad[0] = 1'b1;
    tick();
    periodLoad[0] = 1'b0;
    hallDir[0] = 1'b1;
    hallPhase[0] = 1'b1;
    chEn[0] = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (stepPulse[0]) steps++;
      nChecks++;
      if (stepPulse[0] !== (i % 3 == 0)) begin
        nFails++;
        $display("[TB] FAIL fwd120_timing clk%0d: got step=%b, want %b", i, stepPulse[0], (i % 3 == 0));
      end
      nChecks++;
      if (hallOut[2:0] !== mHall[0] || posCount[15:0] !== 16'(mPos[0])) begin
        nFails++;
        $display("[TB] FAIL fwd120_model clk%0d: got hall=%b pos=%h, want hall=%b pos=%h",
                 i, hallOut[2:0], posCount[15:0], mHall[0], 16'(mPos[0]));
      end
    end
    nChecks++;
    if (steps != 12) begin
      nFails++;
      $display("[TB] FAIL fwd120_count: got %0d steps, want 12", steps);
    end
    nChecks++;
    if (posCount[15:0] !== 16'd12 || hallOut[2:0] !== 3'b100) begin
      nFails++;
      $display("[TB] FAIL fwd120_final: got pos=%h hall=%b, want pos=000c hall=100", posCount[15:0], hallOut[2:0]);
    end
  endtask

  task automatic test_rev60();
    logic [2:0] expSeq [6];
    expSeq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    hallDir[1] = 1'b0;
    hallPhase[1] = 1'b0;
    chEn[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nChecks++;
      if (hallOut[5:3] !== expSeq[i] || stepPulse[1] !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL rev60_seq step%0d: got hall=%b step=%b, want hall=%b step=1",
                 i, hallOut[5:3], stepPulse[1], expSeq[i]);
      end
    end
    nChecks++;
    if (posCount[31:16] !== 16'hFFFA) begin
      nFails++;
      $display("[TB] FAIL rev60_pos: got %h, want fffa", posCount[31:16]);
    end
  endtask

  task automatic test_reload();
    int n;
    periodIn[64 +: PW] = 32'd9;
    periodLoad[2] = 1'b1;
    chEn[2] = 1'b0;
    tick();
    periodLoad[2] = 1'b0;
    hallDir[2] = 1'b1;
    hallPhase[2] = 1'b1;
    chEn[2] = 1'b1;
    waitStep(2, 30, n);
    nChecks++;
    if (n != 10) begin
      nFails++;
      $display("[TB] FAIL reload_first: got interval %0d, want 10", n);
    end
    repeat (4) tick();
    periodIn[64 +: PW] = 32'd3;
    periodLoad[2] = 1'b1;
    tick();
    periodLoad[2] = 1'b0;
    waitStep(2, 30, n);
    nChecks++;
    if (n != 5) begin
      nFails++;
      $display("[TB] FAIL reload_midinterval: got interval %0d, want 10", (n < 0) ? n : n + 5);
    end
    waitStep(2, 30, n);
    nChecks++;
    if (n != 4) begin
      nFails++;
      $display("[TB] FAIL reload_new: got interval %0d, want 4", n);
    end
    repeat (3) tick();
    periodIn[64 +: PW] = 32'd7;
    periodLoad[2] = 1'b1;
    tick();
    periodLoad[2] = 1'b0;
    nChecks++;
    if (stepPulse[2] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reload_coincident_step: got step=%b, want 1", stepPulse[2]);
    end
    waitStep(2, 30, n);
    nChecks++;
    if (n != 8) begin
      nFails++;
      $display("[TB] FAIL reload_coincident: got interval %0d, want 8", n);
    end
    nChecks++;
    if (hallOut[8:6] !== mHall[2] || posCount[47:32] !== 16'(mPos[2])) begin
      nFails++;
      $display("[TB] FAIL reload_state: got hall=%b pos=%h, want hall=%b pos=%h",
               hallOut[8:6], posCount[47:32], mHall[2], 16'(mPos[2]));
    end
  endtask

  task automatic test_pause();
    int n;
    logic [2:0] holdHall;
    int holdPos;
    waitStep(0, 10, n);
    tick();
    chEn[0] = 1'b0;
    tick();
    holdHall = mHall[0];
    holdPos = mPos[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      nChecks++;
      if (stepPulse[0] !== 1'b0 || hallOut[2:0] !== holdHall || posCount[15:0] !== 16'(holdPos)) begin
        nFails++;
        $display("[TB] FAIL pause_frozen clk%0d: got hall=%b step=%b pos=%h, want hall=%b step=0 pos=%h",
                 i, hallOut[2:0], stepPulse[0], posCount[15:0], holdHall, 16'(holdPos));
      end
    end
    hallPhase[0] = ~hallPhase[0];
    tick();
    nChecks++;
    if (hallOut[2:0] !== (hallPhase[0] ? seq120[mIdx[0]] : seq60[mIdx[0]]) || stepPulse[0] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL pause_remap: got hall=%b step=%b, want hall=%b step=0",
               hallOut[2:0], stepPulse[0], hallPhase[0] ? seq120[mIdx[0]] : seq60[mIdx[0]]);
    end
    chEn[0] = 1'b1;
    waitStep(0, 20, n);
    nChecks++;
    if (n != 3) begin
      nFails++;
      $display("[TB] FAIL pause_resume: got first step after %0d clocks, want 3", n);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) chEn[c] = ~chEn[c];
        if ($urandom_range(0, 9) == 0) begin
          periodIn[c*PW +: PW] = $urandom_range(0, 5);
          periodLoad[c] = 1'b1;
        end else begin
          periodLoad[c] = 1'b0;
        end
        if ($urandom_range(0, 15) == 0) hallDir[c] = ~hallDir[c];
        if ($urandom_range(0, 19) == 0) hallPhase[c] = ~hallPhase[c];
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        nChecks++;
        if (hallOut[c*3 +: 3] !== mHall[c] || stepPulse[c] !== mStep[c] || posCount[c*POSW +: POSW] !== 16'(mPos[c])) begin
          nFails++;
          $display("[TB] FAIL random clk%0d ch%0d: got hall=%b step=%b pos=%h, want hall=%b step=%b pos=%h",
                   i, c, hallOut[c*3 +: 3], stepPulse[c], posCount[c*POSW +: POSW],
                   mHall[c], mStep[c], 16'(mPos[c]));
        end
      end
    end
    periodLoad = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    chEn = '1;
    repeat (12) tick();
    reset = 1'b1;
    periodIn[0 +: PW] = 32'd5;
    periodLoad[0] = 1'b1;
    tick();
    periodLoad[0] = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      nChecks++;
      if (hallOut[c*3 +: 3] !== 3'b000 || stepPulse[c] !== 1'b0 || posCount[c*POSW +: POSW] !== 16'h0000) begin
        nFails++;
        $display("[TB] FAIL reset_mid ch%0d: got hall=%b step=%b pos=%h, want 000/0/0000",
                 c, hallOut[c*3 +: 3], stepPulse[c], posCount[c*POSW +: POSW]);
      end
    end
    reset = 1'b0;
    waitStep(0, 10, n);
    nChecks++;
    if (n != 1) begin
      nFails++;
      $display("[TB] FAIL reset_wins_first: got interval %0d, want 1", n);
    end
    waitStep(0, 10, n);
    nChecks++;
    if (n != 1) begin
      nFails++;
      $display("[TB] FAIL reset_wins_second: got interval %0d, want 1", n);
    end
    for (int c = 0; c < NCH; c++) begin
      nChecks++;
      if (hallOut[c*3 +: 3] !== mHall[c] || posCount[c*POSW +: POSW] !== 16'(mPos[c])) begin
        nFails++;
        $display("[TB] FAIL reset_mid_after ch%0d: got hall=%b pos=%h, want hall=%b pos=%h",
                 c, hallOut[c*3 +: 3], posCount[c*POSW +: POSW], mHall[c], 16'(mPos[c]));
      end
    end
  endtask

  task automatic test_wrap();
    wDir = 1'b1;
    wPhase = 1'b1;
    wEn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      nChecks++;
      if (wPos !== 4'(k % 16) || wStep !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL wrap step%0d: got pos=%0d step=%b, want pos=%0d step=1", k, wPos, wStep, k % 16);
      end
    end
    wEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fwd120();
    test_rev60();
    test_reload();
    test_pause();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
